// File: rtl/is_pkg_uart_controller.sv
// is_pkg_uart_controller: shared UART controller constants (DATA_W = byte width)
package is_pkg_uart_controller;
  localparam int DATA_W = 8;
endpackage

// File: rtl/is_uart_hex_word_parser.sv
// is_uart_hex_word_parser: parses ASCII hex digits from a UART byte stream into words
//   clk_i/rst_i       clock, async active-high reset
//   rx_data_i/valid_i/ready_o   byte stream in (ready decoded from state only)
//   word_o/word_valid_o/word_ready_i   parsed word out, held until consumed
//   err_o             one-cycle pulse on bad byte or digit overflow
//   IS_UART_HEX_PREFIX_EN  optional "0x"/"0X" prefix acceptance
module is_uart_hex_word_parser
  import is_pkg_uart_controller::*;
#(
  parameter int NIBBLES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_W-1:0]      rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [4*NIBBLES-1:0]   word_o,
  output logic                   word_valid_o,
  input  logic                   word_ready_i,
  output logic                   err_o
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD, SKIP} state_t;
  state_t state, state_n;
  logic [W-1:0] acc, acc_n, word_n;
  logic [CW-1:0] cnt, cnt_n;
  logic wv_n, err_n, take, is_dig, is_term;
  logic [3:0] dig;
`ifdef IS_UART_HEX_PREFIX_EN
  logic pfx, pfx_n, is_x;
  assign is_x = rx_data_i == 8'h78 || rx_data_i == 8'h58;
`endif
  assign rx_ready_o = state != HOLD;
  assign take = rx_valid_i && rx_ready_o;
  assign is_dig = (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) ||
                  (rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
                  (rx_data_i >= 8'h61 && rx_data_i <= 8'h66);
  // letters A-F/a-f share low nibble 1..6, so +9 maps them to 10..15
  assign dig = rx_data_i[6] ? rx_data_i[3:0] + 4'd9 : rx_data_i[3:0];
  assign is_term = rx_data_i == 8'h0D || rx_data_i == 8'h0A || rx_data_i == 8'h20;
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    word_n = word_o;
    wv_n = word_valid_o;
    err_n = 1'b0;
`ifdef IS_UART_HEX_PREFIX_EN
    pfx_n = pfx;
`endif
    case (state)
      IDLE: if (take) begin
        if (is_dig) begin
          acc_n = W'(dig);
          cnt_n = CW'(1);
          state_n = ACCUM;
`ifdef IS_UART_HEX_PREFIX_EN
          pfx_n = 1'b0;
`endif
        end else if (!is_term) begin
          err_n = 1'b1;
          state_n = SKIP;
        end
      end
      ACCUM: if (take) begin
`ifdef IS_UART_HEX_PREFIX_EN
        if (is_x && cnt == CW'(1) && acc == '0 && !pfx) begin
          cnt_n = '0;
          pfx_n = 1'b1;
        end else if (is_term && cnt == '0) begin
          err_n = 1'b1;
          state_n = IDLE;
        end else
`endif
        if (is_dig && cnt < CW'(NIBBLES)) begin
          acc_n = (acc << 4) | W'(dig);
          cnt_n = cnt + CW'(1);
        end else if (is_term) begin
          word_n = acc;
          wv_n = 1'b1;
          state_n = HOLD;
        end else begin
          err_n = 1'b1;
          state_n = SKIP;
        end
      end
      HOLD: if (word_ready_i) begin
        wv_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = (take && is_term) ? IDLE : SKIP;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      word_o <= '0;
      word_valid_o <= 1'b0;
      err_o <= 1'b0;
`ifdef IS_UART_HEX_PREFIX_EN
      pfx <= 1'b0;
`endif
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      word_o <= word_n;
      word_valid_o <= wv_n;
      err_o <= err_n;
`ifdef IS_UART_HEX_PREFIX_EN
      pfx <= pfx_n;
`endif
    end
  end
endmodule

// File: tb/tb_is_uart_hex_word_parser.sv
// tb_is_uart_hex_word_parser: table-driven and directed scoreboard bench for the hex word parser
module tb_is_uart_hex_word_parser;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [7:0] rx_data_i = '0;
  logic rx_valid_i = 1'b0;
  logic rx_ready_o;
  logic [31:0] word_o;
  logic word_valid_o;
  logic word_ready_i = 1'b1;
  logic err_o;
  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  logic [31:0] exp_q[$];
  typedef struct {
    string s;
    bit has_word;
    logic [31:0] word;
    int errs;
  } vec_t;
  vec_t vecs[10];
  is_uart_hex_word_parser dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .word_o(word_o), .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    if (err_o) err_seen++;
    if (word_valid_o && word_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word got=%h expected none", word_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (word_o !== e) begin
          failures++;
          $display("FAIL word got=%h expected=%h", word_o, e);
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data_i = b;
    rx_valid_i = 1'b1;
    n = 0;
    while (!rx_ready_o && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout got=0 expected=1");
    end
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  initial begin
    int e0;
    vecs[0] = '{"1A2b\015", 1'b1, 32'h00001A2B, 0};
    vecs[1] = '{"123456789 ", 1'b0, 32'h0, 1};
    vecs[2] = '{"7 ", 1'b1, 32'h00000007, 0};
    vecs[3] = '{"12G4\015", 1'b0, 32'h0, 1};
    vecs[4] = '{"\015\015", 1'b0, 32'h0, 0};
    vecs[5] = '{"ffffffff\n", 1'b1, 32'hFFFFFFFF, 0};
    vecs[6] = '{"0\n", 1'b1, 32'h0, 0};
    vecs[7] = '{"x1\015", 1'b0, 32'h0, 1};
`ifdef IS_UART_HEX_PREFIX_EN
    vecs[8] = '{"0xFF\015", 1'b1, 32'h000000FF, 0};
    vecs[9] = '{"0X\015", 1'b0, 32'h0, 1};
`else
    vecs[8] = '{"0xFF\015", 1'b0, 32'h0, 1};
    vecs[9] = '{"a9 ", 1'b1, 32'h000000A9, 0};
`endif
    #2;
    check("reset_word", word_o, 32'h0);
    check("reset_valid", {31'b0, word_valid_o}, 32'h0);
    check("reset_err", {31'b0, err_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("ready_after_reset", {31'b0, rx_ready_o}, 32'h1);
    foreach (vecs[k]) begin
      e0 = err_seen;
      if (vecs[k].has_word) exp_q.push_back(vecs[k].word);
      send_str(vecs[k].s);
      idle(3);
      check({"errs_", vecs[k].s}, err_seen - e0, vecs[k].errs);
      check({"pending_", vecs[k].s}, exp_q.size(), 0);
    end
    // latency and single-cycle valid with consumer always ready
    exp_q.push_back(32'h0000BEEF);
    send_str("BEEF");
    check("valid_before_term", {31'b0, word_valid_o}, 32'h0);
    send_byte(8'h0D);
    check("valid_latency", {31'b0, word_valid_o}, 32'h1);
    idle(1);
    check("valid_one_cycle", {31'b0, word_valid_o}, 32'h0);
    // backpressure: word held 5 cycles, rx blocked
    word_ready_i = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    send_str("DEADBEEF\n");
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'b0, word_valid_o}, 32'h1);
      check("hold_word", word_o, 32'hDEADBEEF);
      check("hold_ready", {31'b0, rx_ready_o}, 32'h0);
      @(posedge clk_i);
      #1;
    end
    word_ready_i = 1'b1;
    idle(1);
    check("hold_released", {31'b0, word_valid_o}, 32'h0);
    check("hold_pending", exp_q.size(), 0);
    // reset mid-word discards partial accumulator
    send_str("AB");
    rst_i = 1'b1;
    #1;
    check("midrst_word", word_o, 32'h0);
    check("midrst_valid", {31'b0, word_valid_o}, 32'h0);
    check("midrst_err", {31'b0, err_o}, 32'h0);
    idle(2);
    rst_i = 1'b0;
    idle(4);
    check("midrst_no_word", {31'b0, word_valid_o}, 32'h0);
    exp_q.push_back(32'h000000CD);
    send_str("CD\015");
    idle(2);
    check("midrst_fresh", exp_q.size(), 0);
    // reset in HOLD drops the pending word
    word_ready_i = 1'b0;
    send_str("55\015");
    check("hold_pre_rst", {31'b0, word_valid_o}, 32'h1);
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    word_ready_i = 1'b1;
    idle(4);
    check("holdrst_no_word", {31'b0, word_valid_o}, 32'h0);
    check("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/is_uart_hex_word_parser.md
IS_UART_HEX_WORD_PARSER -- requirements
Module: is_uart_hex_word_parser

Interface
REQ-001 SHALL have parameter NIBBLES, default 8, giving the maximum hex digits per word (range 1..16).
REQ-002 SHALL take DATA_W (byte width, 8) from is_pkg_uart_controller.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port rx_data_i, input, DATA_W bits, the received ASCII byte.
REQ-006 SHALL have port rx_valid_i, input, 1 bit, which qualifies rx_data_i.
REQ-007 SHALL have port rx_ready_o, output, 1 bit; a byte is accepted when rx_valid_i && rx_ready_o.
REQ-008 SHALL have port word_o, output, 4*NIBBLES bits, the parsed value, right-aligned and zero-extended.
REQ-009 SHALL have port word_valid_o, output, 1 bit, word_o valid.
REQ-010 SHALL have port word_ready_i, input, 1 bit; a word is consumed when word_valid_o && word_ready_i.
REQ-011 SHALL have port err_o, output, 1 bit, a one-cycle error pulse.
REQ-012 SHALL register all outputs (no combinational input-to-output paths), except rx_ready_o, which is decoded from state only.

Function
REQ-013 SHALL classify an accepted byte as one of:
- digit: 0x30-0x39, 0x41-0x46, 0x61-0x66, with values 0-F, case-insensitive;
- terminator: 0x0D, 0x0A, 0x20;
- other: any remaining byte.
REQ-014 SHALL implement FSM states IDLE, ACCUM, HOLD and SKIP.
REQ-015 IDLE:
- digit -> load acc = digit, cnt = 1, go to ACCUM;
- terminator -> ignore, stay in IDLE;
- other -> err_o pulse, go to SKIP.
REQ-016 ACCUM:
- digit with cnt < NIBBLES -> acc = {acc[4*NIBBLES-5:0], digit}, cnt + 1 (MSB-first);
- digit with cnt == NIBBLES -> overflow: err_o pulse, discard acc, go to SKIP;
- terminator -> word_o = acc, word_valid_o = 1 on the next edge, go to HOLD;
- other -> err_o pulse, go to SKIP.
REQ-017 HOLD:
- rx_ready_o = 0;
- word_valid_o and word_o held stable until word_ready_i;
- on consume -> word_valid_o = 0 on the next edge, go to IDLE.
REQ-018 SKIP: discard all bytes until a terminator, then go to IDLE; err_o does not re-pulse inside SKIP.
REQ-019 rx_ready_o SHALL be 1 in IDLE, ACCUM and SKIP.
REQ-020 Latency: word_valid_o rises exactly 1 cycle after the terminator byte is accepted.
REQ-021 Fewer than NIBBLES digits SHALL yield zero-filled upper nibbles; the accumulator SHALL be cleared on entry to ACCUM.
REQ-022 err_o SHALL assert 1 cycle after the offending byte is accepted, for exactly 1 cycle.
REQ-023 Back-to-back bytes (rx_valid_i high every cycle) SHALL be accepted without loss in IDLE, ACCUM and SKIP.

Reset
REQ-024 On rst_i = 1, asynchronously, the block SHALL set:
- state = IDLE, acc = 0, cnt = 0;
- word_o = 0, word_valid_o = 0, err_o = 0.
REQ-025 Reset asserted mid-word or in HOLD SHALL discard the partial or pending word; no word_valid_o after release until a new complete word arrives.
REQ-026 rx_ready_o SHALL be 1 from the first edge after reset release.

Configuration
REQ-027 Macro IS_UART_HEX_PREFIX_EN, when defined, SHALL accept an optional "0x"/"0X" prefix:
- applies in ACCUM when cnt == 1, acc == 0 and no prefix has yet been seen for this word;
- byte 0x78 or 0x58 clears cnt to 0 and sets the prefix-seen flag;
- a terminator with cnt == 0 after a prefix -> err_o pulse, go to IDLE.
REQ-028 Without IS_UART_HEX_PREFIX_EN, 0x78/0x58 SHALL be class "other" (error), and no prefix logic SHALL be synthesised.

Verification
REQ-029 The bench SHALL cover these directed scenarios (NIBBLES = 8 unless stated):
- "1A2b\r", word_ready_i = 1 -> word_o = 0x00001A2B, word_valid_o high 1 cycle, 1 cycle after '\r'.
- "DEADBEEF\n", word_ready_i held 0 for 5 cycles -> word_o = 0xDEADBEEF stable; rx_ready_o = 0 for 5 cycles; consumed on cycle 6.
- "123456789 " -> err_o pulse after the 9th digit, no word; following "7 " -> word_o = 0x00000007.
- "12G4\r" -> err_o pulse after 'G', no word; then "\r\r" -> no word, no error.
- rst_i asserted after "AB" of "ABCD\r" -> no word_valid_o; all outputs 0 during reset.
- With IS_UART_HEX_PREFIX_EN: "0xFF\r" -> word_o = 0x000000FF. Without the macro: the same input -> err_o pulse and no word.
